ram_stream_loader: RTL and testbench
====================================

// Module: ram_stream_loader
// PURPOSE
//  Bulk loader sitting directly upstream of the 4K-word RAM: accepts a valid/ready stream of
//  16-bit words and writes them to consecutive RAM addresses via the RAM's in/load/address port.
//  After the burst it optionally re-reads the same range and compares a 16-bit additive checksum.
//  Used at boot to fill data memory from a host link before the CPU is released.
// PARAMETERS
//  DATA_W     16  word width (matches RAM in/out)
//  ADDR_W     12  RAM address width; addresses wrap modulo 2**ADDR_W
//  VERIFY_EN  1   1: run readback checksum pass after write; 0: skip to DONE
// PORTS
//  clk          in   1         system clock, rising edge
//  rst_n        in   1         asynchronous active-low reset
//  start        in   1         begin burst (sampled in IDLE only)
//  abort        in   1         synchronous abort, returns to IDLE, no done pulse
//  base_addr    in   ADDR_W    first RAM address, latched on start
//  count        in   ADDR_W+1  words to load, latched on start; values > 2**ADDR_W clamp to 2**ADDR_W
//  s_data       in   DATA_W    stream word
//  s_valid      in   1         stream word valid
//  s_ready      out  1         loader accepts word this cycle
//  ram_in       out  DATA_W    to RAM in
//  ram_load     out  1         to RAM load
//  ram_address  out  ADDR_W    to RAM address
//  ram_out      in   DATA_W    from RAM out (combinational read of ram_address)
//  busy         out  1         state != IDLE
//  done         out  1         one-cycle pulse at end of burst
//  pass         out  1         checksum match (sticky until next start; 1 if VERIFY_EN=0)
//  checksum     out  DATA_W    running sum of accepted words, mod 2**DATA_W
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; ptr, remaining, sums, done, pass, checksum all 0;
//   s_ready=0, ram_load=0, ram_address=0, ram_in=0.
//  FSM: IDLE -> WRITE -> VERIFY (if VERIFY_EN) -> DONE -> IDLE.
//  IDLE: start=1 latches ptr=base_addr, remaining=clamp(count), clears sums and pass.
//   count==0 -> DONE directly (pass=1, checksum=0). start ignored outside IDLE.
//  WRITE: s_ready=1; ram_address=ptr; ram_in=s_data; ram_load=s_valid (combinational).
//   Beat accepted on rising edge with s_valid&&s_ready: RAM writes that edge; ptr<=ptr+1
//   (wraps 2**ADDR_W-1 -> 0); remaining--; wsum+=s_data. Last beat (remaining==1) -> VERIFY
//   with ptr reloaded to base, or -> DONE if VERIFY_EN=0. s_valid low stalls with no side effects.
//  VERIFY: s_ready=0, ram_load=0, ram_address=ptr; each cycle rsum+=ram_out, ptr++ (wrap),
//   remaining--; exactly N cycles for N words; then DONE.
//  DONE: one cycle; done=1; pass<=(rsum==wsum) (or 1 if VERIFY_EN=0); -> IDLE.
//  checksum = wsum, updated every accepted beat, holds after DONE until next start.
//  abort=1 in any non-IDLE state: -> IDLE next edge, ram_load forced 0 that cycle,
//   no done pulse, pass=0; abort has priority over a coincident beat.
//  Full burst of 2**ADDR_W words writes every address exactly once; base!=0 wraps through 0.
//  ram_load is never high outside WRITE; RAM contents outside the burst range are untouched.
//  Reset mid-burst: immediate IDLE; words already written stay in RAM.
// TESTING
//  1) base=0x010, count=4, words 1,2,3,4 back-to-back -> RAM[0x010..0x013]=1..4, checksum=10,
//     done at cycle 4+4+1 after start, pass=1.
//  2) base=0xFFE, count=4, words A,B,C,D -> RAM[0xFFE]=A, [0xFFF]=B, [0x000]=C, [0x001]=D.
//  3) s_valid toggled 1,0,0,1,... count=3 -> ram_load only on valid cycles, 3 writes, no extra
//     address advance during stalls.
//  4) Force RAM word corruption between WRITE and VERIFY (bench backdoor) -> done=1, pass=0.
//  5) count=0 -> done one cycle after start, no ram_load, pass=1, checksum=0.
//  6) abort (and separately rst_n low) after 2 of 5 beats -> IDLE, no done, ram_load=0,
//     RAM holds first 2 words; next start runs cleanly.

Source files
------------

// File: rtl/ram_stream_loader.sv
// Bulk loader for a 4K-word RAM.
// Takes a valid/ready stream of words, writes them to consecutive RAM addresses
// (wrapping at the top of the address space), then optionally re-reads the same
// range and compares an additive checksum before reporting done.
module ram_stream_loader #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 12,
  parameter bit VERIFY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_VERIFY,
    S_DONE
  } state_e;

  // Largest burst: one full sweep of the address space.
  localparam logic [ADDR_W:0]   FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  state_e              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     remaining_q;
  logic [DATA_W-1:0]   wsum_q;
  logic [DATA_W-1:0]   rsum_q;
  logic                pass_q;

  logic [ADDR_W:0]     count_clamped;
  logic [DATA_W-1:0]   rsum_next;
  logic                beat;

  // Any count with the top bit set is at least a full sweep.
  assign count_clamped = count[ADDR_W] ? FULL_LEN : count;
  assign rsum_next     = rsum_q + ram_out;

  // A beat is a write; abort suppresses a coincident beat so the RAM is not touched.
  assign beat        = (state_q == S_WRITE) && s_valid && !abort;

  assign s_ready     = (state_q == S_WRITE);
  assign ram_load    = beat;
  assign ram_in      = (state_q == S_WRITE) ? s_data : '0;
  assign ram_address = ptr_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign pass        = pass_q;
  assign checksum    = wsum_q;

  // Burst sequencer: latch the job, stream writes, optional readback, report.
  // NOTE: every register here is assigned with <= so all updates see the
  // pre-edge values; the async reset branch clears all state, there is no
  // memory array in this block to worry about.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      base_q      <= '0;
      len_q       <= '0;
      remaining_q <= '0;
      wsum_q      <= '0;
      rsum_q      <= '0;
      pass_q      <= 1'b0;
    end else if (abort && state_q != S_IDLE) begin
      state_q <= S_IDLE;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ptr_q       <= base_addr;
            base_q      <= base_addr;
            len_q       <= count_clamped;
            remaining_q <= count_clamped;
            wsum_q      <= '0;
            rsum_q      <= '0;
            if (count_clamped == '0) begin
              pass_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              pass_q  <= 1'b0;
              state_q <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (s_valid) begin
            ptr_q       <= ptr_q + PTR_ONE;
            remaining_q <= remaining_q - LEN_ONE;
            wsum_q      <= wsum_q + s_data;
            if (remaining_q == LEN_ONE) begin
              if (VERIFY_EN) begin
                ptr_q       <= base_q;
                remaining_q <= len_q;
                state_q     <= S_VERIFY;
              end else begin
                pass_q  <= 1'b1;
                state_q <= S_DONE;
              end
            end
          end
        end
        S_VERIFY: begin
          rsum_q      <= rsum_next;
          ptr_q       <= ptr_q + PTR_ONE;
          remaining_q <= remaining_q - LEN_ONE;
          if (remaining_q == LEN_ONE) begin
            // Result is resolved on entry to DONE so it is valid alongside done.
            pass_q  <= (rsum_next == wsum_q);
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_loader.sv
// Bench for ram_stream_loader: behavioural RAM, a queue-based scoreboard for RAM
// writes and done reports, and a reference image of RAM contents.
module tb_ram_stream_loader;

  localparam int DW    = 16;
  localparam int AW    = 12;
  localparam int DEPTH = 4096;
  localparam int BOUND = 10000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] ram_in;
  logic          ram_load;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_out;
  logic          busy;
  logic          done;
  logic          pass;
  logic [DW-1:0] checksum;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [DW-1:0] sum;
    logic          ok;
  } dn_t;

  wr_t exp_wr[$];
  dn_t exp_dn[$];

  ram_stream_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .base_addr   (base_addr),
    .count       (count),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .ram_in      (ram_in),
    .ram_load    (ram_load),
    .ram_address (ram_address),
    .ram_out     (ram_out),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .checksum    (checksum)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: combinational read, write on rising edge.
  assign ram_out = mem[ram_address];
  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_ram(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    check_eq(name, 32'(bad), 32'd0);
  endtask

  // Monitor: every RAM write and every done pulse must match the next expectation.
  always @(negedge clk) begin
    if (rst_n && ram_load) begin
      check_eq("write_expected", 32'(exp_wr.size() > 0), 32'd1);
      if (exp_wr.size() > 0) begin
        wr_t e;
        e = exp_wr.pop_front();
        check_eq("write_addr", 32'(ram_address), 32'(e.addr));
        check_eq("write_data", 32'(ram_in), 32'(e.data));
      end
    end
    if (rst_n && done) begin
      check_eq("done_expected", 32'(exp_dn.size() > 0), 32'd1);
      if (exp_dn.size() > 0) begin
        dn_t d;
        d = exp_dn.pop_front();
        check_eq("done_checksum", 32'(checksum), 32'(d.sum));
        check_eq("done_pass", 32'(pass), 32'(d.ok));
      end
    end
  end

  // One burst. mode 0: back-to-back, 1: valid pattern 1,0,0 repeating,
  // 2: random valid with stray start pulses. want_lat > 0 also checks the
  // absolute start-to-done cycle count.
  task automatic run_burst(input logic [AW-1:0] base, input logic [AW:0] cnt, input int mode,
                           input bit corrupt, input bit seq_words, input int want_lat);
    int            n, cyc, i, k, want;
    logic [DW-1:0] words[$];
    logic [DW-1:0] sum, w;
    logic [AW-1:0] a;
    bit            acc, v, seen;
    n   = (cnt > 13'd4096) ? DEPTH : int'(cnt);
    sum = '0;
    for (int j = 0; j < n; j++) begin
      w = seq_words ? DW'(j + 1) : DW'($urandom);
      words.push_back(w);
      sum = sum + w;
      a = AW'(int'(base) + j);
      exp_wr.push_back(wr_t'{addr: a, data: w});
      ref_mem[a] = w;
    end
    exp_dn.push_back(dn_t'{sum: sum, ok: !corrupt});

    @(posedge clk); #1;
    start = 1'b1; base_addr = base; count = cnt;
    @(posedge clk); #1;
    start = 1'b0; base_addr = AW'($urandom); count = (AW+1)'($urandom);
    cyc = 1; i = 0; k = 0;
    while (i < n && cyc < BOUND) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (k % 3 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      if (mode == 2) start = 1'($urandom_range(0, 1));
      s_valid = v;
      s_data  = v ? words[i] : DW'($urandom);
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      cyc++; k++;
      if (acc) begin
        i++;
        if (corrupt && i == 2) begin
          mem[base] <= mem[base] ^ 16'h0001;
          ref_mem[base] = ref_mem[base] ^ 16'h0001;
        end
      end
    end
    s_valid = 1'b0; start = 1'b0;
    check_eq("beats_accepted", 32'(i), 32'(n));

    // Readback takes one cycle per word, then done appears.
    want = (n == 0) ? 1 : cyc + n;
    seen = 1'b0;
    while (!seen && cyc < BOUND) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    check_eq("done_latency", 32'(cyc), 32'(want));
    if (want_lat > 0) check_eq("done_cycle_from_start", 32'(cyc), 32'(want_lat));
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("idle_after_done", 32'(busy), 32'd0);
    check_eq("checksum_held", 32'(checksum), 32'(sum));
    check_eq("pass_held", 32'(pass), 32'(!corrupt));
    check_ram("ram_image");
  endtask

  // Five-word burst cut short after two beats by abort or by reset.
  task automatic run_abort(input logic [AW-1:0] base, input bit use_rst);
    logic [DW-1:0] words[5];
    int            i, cyc;
    bit            acc;
    logic [AW-1:0] a;
    for (int j = 0; j < 5; j++) words[j] = DW'($urandom);
    for (int j = 0; j < 2; j++) begin
      a = AW'(int'(base) + j);
      exp_wr.push_back(wr_t'{addr: a, data: words[j]});
      ref_mem[a] = words[j];
    end
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; count = 13'd5;
    @(posedge clk); #1;
    start = 1'b0;
    i = 0; cyc = 0;
    while (i < 2 && cyc < BOUND) begin
      s_valid = 1'b1; s_data = words[i];
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) i++;
    end
    check_eq("beats_before_cut", 32'(i), 32'd2);
    // Third beat is offered in the same cycle as the cut.
    s_valid = 1'b1; s_data = words[2];
    if (use_rst) rst_n = 1'b0;
    else abort = 1'b1;
    @(negedge clk);
    check_eq("cut_no_load", 32'(ram_load), 32'd0);
    if (use_rst) check_eq("reset_idle_at_once", 32'(busy), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0; s_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check_eq("cut_idle", 32'(busy), 32'd0);
    check_eq("cut_pass_low", 32'(pass), 32'd0);
    check_eq("cut_no_done", 32'(done), 32'd0);
    if (use_rst) check_eq("reset_checksum", 32'(checksum), 32'd0);
    repeat (4) @(posedge clk);
    check_ram("ram_after_cut");
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     <= DW'(i * 7 + 3);
      ref_mem[i]  = DW'(i * 7 + 3);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_s_ready", 32'(s_ready), 32'd0);
    check_eq("rst_ram_load", 32'(ram_load), 32'd0);
    check_eq("rst_ram_address", 32'(ram_address), 32'd0);
    check_eq("rst_ram_in", 32'(ram_in), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_pass", 32'(pass), 32'd0);
    check_eq("rst_checksum", 32'(checksum), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_burst(12'h010, 13'd4, 0, 1'b0, 1'b1, 9);     // words 1..4, sum 10
    check_eq("seq_checksum_10", 32'(checksum), 32'd10);
    run_burst(12'hFFE, 13'd4, 0, 1'b0, 1'b0, 0);     // wrap through 0
    run_burst(12'h123, 13'd3, 1, 1'b0, 1'b0, 0);     // stalls
    run_burst(12'h200, 13'd4, 0, 1'b1, 1'b0, 0);     // corrupted readback
    run_burst(12'h050, 13'd0, 0, 1'b0, 1'b0, 1);     // empty burst
    run_abort(12'h300, 1'b0);
    run_burst(12'h300, 13'd5, 0, 1'b0, 1'b0, 0);
    run_abort(12'h400, 1'b1);
    run_burst(12'h400, 13'd5, 2, 1'b0, 1'b0, 0);
    run_burst(12'h123, 13'h1FFF, 0, 1'b0, 1'b0, 0);  // clamps to full sweep
    for (int r = 0; r < 6; r++)
      run_burst(AW'($urandom), 13'($urandom_range(1, 40)), 2, 1'b0, 1'b0, 0);

    check_eq("writes_left_over", 32'(exp_wr.size()), 32'd0);
    check_eq("dones_left_over", 32'(exp_dn.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "time limit");
  end

endmodule
